smpl_iter_tx: RTL and testbench

//  Sample iterator: source side of the sample interface consumed by the sample test
//  and sample-count scoreboard (validSamp/sample/tri/color). Accepts one bounding-boxed

---
 rtl/smpl_iter_tx.sv | 157 +++++++++++++++
 tb/tb_smpl_iter_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smpl_iter_tx.sv
// Sample iterator: accepts one bounding-boxed triangle at a time and emits every
// subsample position inside the snapped box, one per cycle, in raster order.
module smpl_iter_tx #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R13S,
   input  logic [COLORS-1:0][SIGFIG-1:0]            color_R13U,
   input  logic [1:0][1:0][SIGFIG-1:0]              box_R13S,
   input  logic                                     validTri_R13H,
   input  logic [3:0]                               subSample_RnnnnU,
   output logic                                     halt_RnnnnL,
   output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R14S,
   output logic [COLORS-1:0][SIGFIG-1:0]            color_R14U,
   output logic [1:0][SIGFIG-1:0]                   sample_R14S,
   output logic                                     validSamp_R14H
);

   localparam logic [0:0] WAIT = 1'b0;
   localparam logic [0:0] TEST = 1'b1;
   localparam logic [SIGFIG-1:0] ONE = SIGFIG'(1);

   logic [0:0]                               state_q, state_d;
   logic                                     halt_q, halt_d;
   logic                                     valid_q, valid_d;
   logic [SIGFIG-1:0]                        x_q, x_d, y_q, y_d;
   logic [SIGFIG-1:0]                        ll_x_q, ll_x_d, ur_x_q, ur_x_d, ur_y_q, ur_y_d;
   logic [SIGFIG-1:0]                        step_q, step_d;
   logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_q, tri_d;
   logic [COLORS-1:0][SIGFIG-1:0]            color_q, color_d;

   int                                       shamt;
   logic [SIGFIG-1:0]                        step_in, mask_in;
   logic [SIGFIG-1:0]                        snap_llx, snap_lly, snap_urx, snap_ury;
   logic                                     box_empty;
   logic [SIGFIG:0]                          x_nxt, y_nxt;
   logic                                     x_fits, y_fits;

   // Step and grid snap for the incoming triangle; snapping masks toward -inf.
   always_comb begin
      case (subSample_RnnnnU)
         4'b0001: shamt = RADIX - 3;
         4'b0010: shamt = RADIX - 2;
         4'b0100: shamt = RADIX - 1;
         default: shamt = RADIX;
      endcase
      step_in   = ONE << shamt;
      mask_in   = ~(step_in - ONE);
      snap_llx  = box_R13S[0][0] & mask_in;
      snap_lly  = box_R13S[0][1] & mask_in;
      snap_urx  = box_R13S[1][0] & mask_in;
      snap_ury  = box_R13S[1][1] & mask_in;
      box_empty = ($signed(snap_llx) > $signed(snap_urx)) ||
                  ($signed(snap_lly) > $signed(snap_ury));
   end

   // One extra bit keeps x+step from wrapping when UR sits near the positive limit.
   always_comb begin
      x_nxt  = {x_q[SIGFIG-1], x_q} + {1'b0, step_q};
      y_nxt  = {y_q[SIGFIG-1], y_q} + {1'b0, step_q};
      x_fits = $signed(x_nxt) <= $signed({ur_x_q[SIGFIG-1], ur_x_q});
      y_fits = $signed(y_nxt) <= $signed({ur_y_q[SIGFIG-1], ur_y_q});
   end

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      halt_d  = halt_q;
      valid_d = valid_q;
      x_d     = x_q;
      y_d     = y_q;
      ll_x_d  = ll_x_q;
      ur_x_d  = ur_x_q;
      ur_y_d  = ur_y_q;
      step_d  = step_q;
      tri_d   = tri_q;
      color_d = color_q;
      case (state_q)
         WAIT: begin
            if (validTri_R13H) begin
               tri_d   = tri_R13S;
               color_d = color_R13U;
               ll_x_d  = snap_llx;
               ur_x_d  = snap_urx;
               ur_y_d  = snap_ury;
               step_d  = step_in;
               if (!box_empty) begin
                  x_d     = snap_llx;
                  y_d     = snap_lly;
                  valid_d = 1'b1;
                  halt_d  = 1'b0;
                  state_d = TEST;
               end
            end
         end
         TEST: begin
            if (x_fits) begin
               x_d = x_nxt[SIGFIG-1:0];
            end else if (y_fits) begin
               x_d = ll_x_q;
               y_d = y_nxt[SIGFIG-1:0];
            end else begin
               valid_d = 1'b0;
               halt_d  = 1'b1;
               state_d = WAIT;
            end
         end
         default: begin
            valid_d = 1'b0;
            halt_d  = 1'b1;
            state_d = WAIT;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= WAIT;
         halt_q  <= 1'b1;
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         ll_x_q  <= '0;
         ur_x_q  <= '0;
         ur_y_q  <= '0;
         step_q  <= '0;
         tri_q   <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         halt_q  <= halt_d;
         valid_q <= valid_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ll_x_q  <= ll_x_d;
         ur_x_q  <= ur_x_d;
         ur_y_q  <= ur_y_d;
         step_q  <= step_d;
         tri_q   <= tri_d;
         color_q <= color_d;
      end
   end

   assign halt_RnnnnL    = halt_q;
   assign validSamp_R14H = valid_q;
   assign sample_R14S[0] = x_q;
   assign sample_R14S[1] = y_q;
   assign tri_R14S       = tri_q;
   assign color_R14U     = color_q;

endmodule

// File: tb/tb_smpl_iter_tx.sv
// Directed bench for smpl_iter_tx: each scenario task drives triangles and scores
// the emitted samples against a raster-walk reference model.
module tb_smpl_iter_tx;

   localparam int SIGFIG = 24;
   localparam int VERTS  = 3;
   localparam int AXIS   = 3;
   localparam int COLORS = 3;

   typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
   typedef logic [COLORS-1:0][SIGFIG-1:0]          color_t;

   logic                            clk = 1'b0;
   logic                            rst = 1'b0;
   tri_t                            tri_in;
   color_t                          color_in;
   logic [1:0][1:0][SIGFIG-1:0]     box_in;
   logic                            valid_tri;
   logic [3:0]                      ss;
   logic                            halt;
   tri_t                            tri_out;
   color_t                          color_out;
   logic [1:0][SIGFIG-1:0]          sample;
   logic                            valid_samp;

   int total = 0;
   int bad   = 0;
   int exp_x[$];
   int exp_y[$];
   int n_seen, halt_low, last_x, last_y;

   always #5 clk = ~clk;

   smpl_iter_tx dut (
      .clk              (clk),
      .rst              (rst),
      .tri_R13S         (tri_in),
      .color_R13U       (color_in),
      .box_R13S         (box_in),
      .validTri_R13H    (valid_tri),
      .subSample_RnnnnU (ss),
      .halt_RnnnnL      (halt),
      .tri_R14S         (tri_out),
      .color_R14U       (color_out),
      .sample_R14S      (sample),
      .validSamp_R14H   (valid_samp)
   );

   function automatic tri_t mk_tri(input int tag);
      tri_t t;
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            t[v][a] = SIGFIG'(tag * 16 + v * 4 + a);
      return t;
   endfunction

   function automatic color_t mk_color(input int tag);
      color_t c;
      for (int k = 0; k < COLORS; k++) c[k] = SIGFIG'(tag * 256 + k);
      return c;
   endfunction

   // Reference model: snap box to the subsample grid and walk it in raster order.
   task automatic build_model(input int llx, input int lly, input int urx, input int ury,
                              input logic [3:0] ss_v);
      int lg, step, sx0, sy0, sx1, sy1;
      lg   = ss_v[0] ? 3 : ss_v[1] ? 2 : ss_v[2] ? 1 : 0;
      step = 1 << (10 - lg);
      sx0  = llx & ~(step - 1);
      sy0  = lly & ~(step - 1);
      sx1  = urx & ~(step - 1);
      sy1  = ury & ~(step - 1);
      exp_x.delete();
      exp_y.delete();
      for (int y = sy0; y <= sy1; y += step)
         for (int x = sx0; x <= sx1; x += step) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
         end
   endtask

   task automatic set_tri(input int llx, input int lly, input int urx, input int ury,
                          input logic [3:0] ss_v, input int tag);
      box_in[0][0] = SIGFIG'(llx);
      box_in[0][1] = SIGFIG'(lly);
      box_in[1][0] = SIGFIG'(urx);
      box_in[1][1] = SIGFIG'(ury);
      ss           = ss_v;
      tri_in       = mk_tri(tag);
      color_in     = mk_color(tag);
      valid_tri    = 1'b1;
      build_model(llx, lly, urx, ury, ss_v);
   endtask

   // Present a triangle for one accept edge; returns at the first-sample cycle.
   task automatic drive_tri(input int llx, input int lly, input int urx, input int ury,
                            input logic [3:0] ss_v, input int tag);
      @(negedge clk);
      set_tri(llx, lly, urx, ury, ss_v, tag);
      @(negedge clk);
      valid_tri = 1'b0;
   endtask

   // Score consecutive samples against the model until validSamp drops.
   task automatic walk_and_score(input string name);
      int ax, ay, budget;
      n_seen   = 0;
      halt_low = 0;
      budget   = 300;
      while (valid_samp === 1'b1 && budget > 0) begin
         ax = int'($signed(sample[0]));
         ay = int'($signed(sample[1]));
         if (halt === 1'b0) halt_low++;
         total++;
         if (n_seen >= exp_x.size()) begin
            bad++;
            $display("FAIL %s extra sample #%0d got (%0d,%0d) model has %0d samples",
                     name, n_seen, ax, ay, exp_x.size());
         end else if (ax !== exp_x[n_seen] || ay !== exp_y[n_seen]) begin
            bad++;
            $display("FAIL %s sample #%0d got (%0d,%0d) want (%0d,%0d)",
                     name, n_seen, ax, ay, exp_x[n_seen], exp_y[n_seen]);
         end
         last_x = ax;
         last_y = ay;
         n_seen++;
         budget--;
         @(negedge clk);
      end
      total++;
      if (budget == 0) begin
         bad++;
         $display("FAIL %s walk timeout got >=%0d samples want %0d", name, n_seen, exp_x.size());
      end else if (n_seen !== exp_x.size()) begin
         bad++;
         $display("FAIL %s count got %0d want %0d", name, n_seen, exp_x.size());
      end
      total++;
      if (halt !== 1'b1) begin
         bad++;
         $display("FAIL %s halt_after_walk got %b want 1", name, halt);
      end
   endtask

   task automatic test_reset();
      #12;
      total++;
      if (halt !== 1'b1 || valid_samp !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctl got halt=%b valid=%b want halt=1 valid=0", halt, valid_samp);
      end
      total++;
      if (sample !== '0 || tri_out !== '0 || color_out !== '0) begin
         bad++;
         $display("FAIL reset_data got sample=%h tri=%h color=%h want 0", sample, tri_out, color_out);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_ss1_2x2();
      drive_tri(0, 0, 1024, 1024, 4'b1000, 1);
      walk_and_score("ss1_2x2");
      total++;
      if (n_seen !== 4 || halt_low !== 4 || last_x !== 1024 || last_y !== 1024) begin
         bad++;
         $display("FAIL ss1_2x2 got n=%0d halt_low=%0d last=(%0d,%0d) want 4 4 (1024,1024)",
                  n_seen, halt_low, last_x, last_y);
      end
   endtask

   task automatic test_ss8_grid();
      drive_tri(0, 0, 896, 896, 4'b0001, 2);
      walk_and_score("ss8_grid");
      total++;
      if (n_seen !== 64 || last_x !== 896 || last_y !== 896) begin
         bad++;
         $display("FAIL ss8_grid got n=%0d last=(%0d,%0d) want 64 (896,896)", n_seen, last_x, last_y);
      end
   endtask

   task automatic test_snap();
      drive_tri(100, 300, 600, 300, 4'b0010, 3);
      total++;
      if (tri_out !== mk_tri(3) || color_out !== mk_color(3)) begin
         bad++;
         $display("FAIL snap_latch got tri=%h color=%h want tag 3", tri_out, color_out);
      end
      walk_and_score("snap_ss4");
      total++;
      if (n_seen !== 3 || last_x !== 512 || last_y !== 256) begin
         bad++;
         $display("FAIL snap_ss4 got n=%0d last=(%0d,%0d) want 3 (512,256)", n_seen, last_x, last_y);
      end
      drive_tri(100, 300, 600, 300, 4'b0100, 4);
      walk_and_score("snap_ss2");
      total++;
      if (n_seen !== 2 || last_x !== 512 || last_y !== 0) begin
         bad++;
         $display("FAIL snap_ss2 got n=%0d last=(%0d,%0d) want 2 (512,0)", n_seen, last_x, last_y);
      end
   endtask

   task automatic test_negative_and_max();
      drive_tri(-1500, -100, -1, 0, 4'b1000, 5);
      walk_and_score("negative");
      total++;
      if (n_seen !== 4 || last_x !== -1024 || last_y !== 0) begin
         bad++;
         $display("FAIL negative got n=%0d last=(%0d,%0d) want 4 (-1024,0)", n_seen, last_x, last_y);
      end
      drive_tri(32'h7FF800, 0, 32'h7FFFFF, 0, 4'b1000, 6);
      walk_and_score("no_wrap");
      total++;
      if (n_seen !== 2 || last_x !== 32'h7FFC00) begin
         bad++;
         $display("FAIL no_wrap got n=%0d last_x=%0d want 2 %0d", n_seen, last_x, 32'h7FFC00);
      end
   endtask

   task automatic test_empty_box();
      @(negedge clk);
      set_tri(2048, 0, 1024, 0, 4'b1000, 7);
      @(negedge clk);
      total++;
      if (valid_samp !== 1'b0 || halt !== 1'b1) begin
         bad++;
         $display("FAIL empty_box got valid=%b halt=%b want 0 1", valid_samp, halt);
      end
      set_tri(0, 0, 0, 0, 4'b1000, 8);
      @(negedge clk);
      valid_tri = 1'b0;
      total++;
      if (valid_samp !== 1'b1 || tri_out !== mk_tri(8)) begin
         bad++;
         $display("FAIL empty_next_accept got valid=%b tri=%h want 1 tag 8", valid_samp, tri_out);
      end
      walk_and_score("empty_next");
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      set_tri(1024, 1024, 1024, 1024, 4'b1000, 9);
      @(negedge clk);
      total++;
      if (valid_samp !== 1'b1 || halt !== 1'b0 || tri_out !== mk_tri(9)) begin
         bad++;
         $display("FAIL b2b_first got valid=%b halt=%b tri=%h want 1 0 tag 9", valid_samp, halt, tri_out);
      end
      set_tri(2048, 0, 2048, 0, 4'b1000, 10);
      @(negedge clk);
      total++;
      if (valid_samp !== 1'b0 || halt !== 1'b1 || tri_out !== mk_tri(9)) begin
         bad++;
         $display("FAIL b2b_gap got valid=%b halt=%b tri=%h want 0 1 tag 9", valid_samp, halt, tri_out);
      end
      @(negedge clk);
      valid_tri = 1'b0;
      total++;
      if (valid_samp !== 1'b1 || tri_out !== mk_tri(10) || color_out !== mk_color(10)) begin
         bad++;
         $display("FAIL b2b_second got valid=%b tri=%h want 1 tag 10", valid_samp, tri_out);
      end
      walk_and_score("b2b_second");
   endtask

   task automatic test_reset_mid_walk();
      drive_tri(0, 0, 896, 896, 4'b0001, 11);
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      total++;
      if (valid_samp !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_valid got %b want 0", valid_samp);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (valid_samp !== 1'b0 || halt !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_idle cycle %0d got valid=%b halt=%b want 0 1", i, valid_samp, halt);
         end
      end
   endtask

   initial begin
      tri_in    = '0;
      color_in  = '0;
      box_in    = '0;
      valid_tri = 1'b0;
      ss        = 4'b1000;
      test_reset();
      test_ss1_2x2();
      test_ss8_grid();
      test_snap();
      test_negative_and_max();
      test_empty_box();
      test_back_to_back();
      test_reset_mid_walk();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
